bcd_digit_collector: RTL and testbench

Downstream sequencer and consumer for the sequential binary-to-decimal converter. It takes a 27-bit binary value through a valid/ready handshake and issues the converter's start pulse and next-digit pulses. It samples the 4-bit digit after each digit settles and packs eight digits into a 32-bit BCD word. It then presents that word with a leading-zero blank mask and an overflow flag to the display/output logic, through a second valid/ready handshake.

---
 rtl/bcd_digit_collector_if.sv | 36 +++
 rtl/bcd_digit_collector.sv | 130 +++++++++++++
 tb/tb_bcd_digit_collector.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_digit_collector_if.sv
// Signal bundle between the BCD digit collector, its upstream source, the
// sequential binary-to-decimal converter and the display/output consumer.
interface bcd_digit_collector_if #(
  parameter int unsigned BIN_W  = 27,
  parameter int unsigned DIGITS = 8
) ();
  // Upstream binary value handshake
  logic                  bin_valid;
  logic                  bin_ready;
  logic [BIN_W-1:0]      bin_data;
  // Converter control and digit return
  logic [BIN_W-1:0]      conv_bin;
  logic                  conv_req_pls;
  logic                  conv_next_pls;
  logic [3:0]            conv_dec;
  // Result handshake
  logic [4*DIGITS-1:0]   bcd_out;
  logic [DIGITS-1:0]     blank_mask;
  logic                  ovf;
  logic                  out_valid;
  logic                  out_ready;

  // Collector side
  modport master (
    input  bin_valid, bin_data, conv_dec, out_ready,
    output bin_ready, conv_bin, conv_req_pls, conv_next_pls,
    output bcd_out, blank_mask, ovf, out_valid
  );

  // Environment side (source, converter, consumer)
  modport slave (
    output bin_valid, bin_data, conv_dec, out_ready,
    input  bin_ready, conv_bin, conv_req_pls, conv_next_pls,
    input  bcd_out, blank_mask, ovf, out_valid
  );
endinterface

// File: rtl/bcd_digit_collector.sv
// Sequencer/consumer for a sequential binary-to-decimal converter: accepts a
// binary value, pulses the converter through its digits, packs the captured
// digits MSB-first into a BCD word and presents it with a leading-zero mask.
module bcd_digit_collector #(
  parameter int unsigned BIN_W  = 27,
  parameter int unsigned DIGITS = 8,
  parameter int unsigned SETTLE = 5
) (
  input logic                   clk,
  input logic                   reset_n,
  bcd_digit_collector_if.master bus_io
);
  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [63:0] max_value(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MaxVal = max_value(DIGITS);

  typedef enum logic [2:0] {StIdle, StStart, StWait, StCapture, StNext, StDone} state_e;

  state_e            state_q, state_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [DIGITS-1:0] mask_q, mask_d;
  logic              ovf_q, ovf_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [BcdW-1:0]   bcd_shift;
  logic [DIGITS-1:0] mask_calc;

  // Word as it will look once the digit currently on conv_dec is shifted in
  always_comb begin
    bcd_shift = {bcd_q[BcdW-5:0], bus_io.conv_dec};
  end

  // Leading-zero mask of the shifted word; digit 0 is never blanked, nothing
  // is blanked on overflow
  always_comb begin
    logic all_zero;
    mask_calc = '0;
    all_zero  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero     = all_zero && (bcd_shift[4*i +: 4] == 4'd0);
      mask_calc[i] = all_zero && !ovf_q;
    end
  end

  // Next-state logic for the sequencer and its datapath registers
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    mask_d  = mask_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.bin_valid) begin
          bin_d   = bus_io.bin_data;
          ovf_d   = (64'(bus_io.bin_data) > MaxVal);
          bcd_d   = '0;
          idx_d   = IdxW'(DIGITS - 1);
          state_d = StStart;
        end
      end
      StStart, StNext: begin
        cnt_d   = 4'(SETTLE);
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StCapture;
      end
      StCapture: begin
        bcd_d = bcd_shift;
        if (idx_q == '0) begin
          mask_d  = mask_calc;
          state_d = StDone;
        end else begin
          idx_d   = idx_q - IdxW'(1);
          state_d = StNext;
        end
      end
      StDone: begin
        if (bus_io.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      bin_q   <= '0;
      bcd_q   <= '0;
      mask_q  <= '0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      mask_q  <= mask_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decoded from the registered state
  always_comb begin
    bus_io.bin_ready     = (state_q == StIdle);
    bus_io.conv_req_pls  = (state_q == StStart);
    bus_io.conv_next_pls = (state_q == StNext);
    bus_io.out_valid     = (state_q == StDone);
    bus_io.conv_bin      = bin_q;
    bus_io.bcd_out       = bcd_q;
    bus_io.blank_mask    = mask_q;
    bus_io.ovf           = ovf_q;
  end
endmodule

// File: tb/tb_bcd_digit_collector.sv
// Bench for bcd_digit_collector: behavioural converter model, vector table
// feeding a result scoreboard, pulse audit and a mid-conversion reset case.
module tb_bcd_digit_collector;
  logic clk;
  logic reset_n;
  int   cyc;
  int   n_checks;
  int   n_pass;

  bcd_digit_collector_if #(.BIN_W(27), .DIGITS(8)) bus ();

  bcd_digit_collector #(.BIN_W(27), .DIGITS(8), .SETTLE(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus_io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Digit p (0 = least significant) of v; the top digit is passed raw
  function automatic logic [3:0] digit_of(input int unsigned v, input int p);
    int unsigned pw;
    int unsigned q;
    pw = 1;
    for (int i = 0; i < p; i++) pw = pw * 10;
    q = v / pw;
    if (p < 7) q = q % 10;
    return q[3:0];
  endfunction

  // Converter model: digit is garbage for 4 cycles after each pulse
  int unsigned mdl_val;
  int          mdl_pos;
  int          mdl_dly;
  logic [3:0]  mdl_digit;
  always @(negedge clk) begin
    if (bus.conv_req_pls) begin
      mdl_val = 32'(bus.conv_bin);
      mdl_pos = 7;
      mdl_dly = 4;
    end else if (bus.conv_next_pls) begin
      mdl_pos = mdl_pos - 1;
      mdl_dly = 4;
    end else if (mdl_dly > 0) begin
      mdl_dly = mdl_dly - 1;
    end
    mdl_digit = digit_of(mdl_val, mdl_pos);
  end
  assign bus.conv_dec = (mdl_dly != 0) ? 4'hE : mdl_digit;

  // Pulse audit: cumulative counters, differenced per conversion
  int req_cnt, next_cnt, overlap, gap_err, last_pulse;
  always @(negedge clk) begin
    if (bus.conv_req_pls && bus.conv_next_pls) overlap = overlap + 1;
    if (bus.conv_req_pls) begin
      req_cnt    = req_cnt + 1;
      last_pulse = cyc;
    end
    if (bus.conv_next_pls) begin
      next_cnt = next_cnt + 1;
      if (cyc - last_pulse != 7) gap_err = gap_err + 1;
      last_pulse = cyc;
    end
  end

  typedef struct {
    logic [31:0] bcd;
    logic [7:0]  mask;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [26:0] v;
    logic [31:0] bcd;
    logic [7:0]  mask;
    logic        ovf;
    int          hold;
    bit          early;
    bit          noise;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   accept_cyc;
  int   req0, next0, ov0, gap0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  function automatic exp_t model(input logic [26:0] v);
    exp_t e;
    logic z;
    e.bcd = '0;
    for (int p = 7; p >= 0; p--) e.bcd = {e.bcd[27:0], digit_of(32'(v), p)};
    e.ovf  = (v > 27'd99_999_999);
    e.mask = '0;
    z      = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      z         = z && (e.bcd[4*i +: 4] == 4'd0);
      e.mask[i] = z && !e.ovf;
    end
    return e;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_bin_ready"}, 64'(bus.bin_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_pulses"}, 64'({bus.conv_req_pls, bus.conv_next_pls}), 64'd0);
    check({tag, "_bcd_out"}, 64'(bus.bcd_out), 64'd0);
    check({tag, "_mask_ovf"}, 64'({bus.blank_mask, bus.ovf}), 64'd0);
    check({tag, "_conv_bin"}, 64'(bus.conv_bin), 64'd0);
  endtask

  task automatic send(input logic [26:0] v, input bit noise);
    int n;
    n = 0;
    @(negedge clk);
    bus.bin_valid = 1'b1;
    bus.bin_data  = v;
    while (!bus.bin_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 64'(bus.bin_ready), 64'd1);
    req0  = req_cnt;
    next0 = next_cnt;
    ov0   = overlap;
    gap0  = gap_err;
    @(posedge clk);
    @(negedge clk);
    accept_cyc = cyc;
    // Busy-time noise on the input must not disturb the conversion
    if (noise) bus.bin_data = ~v;
    else bus.bin_valid = 1'b0;
  endtask

  task automatic get_result(input int hold);
    int   n;
    bit   stable;
    exp_t e;
    logic [31:0] snap;
    n      = 0;
    stable = 1'b1;
    while (!bus.out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_timeout", 64'(bus.out_valid), 64'd1);
    check("latency", 64'(cyc - accept_cyc), 64'd56);
    check("bin_ready_in_done", 64'(bus.bin_ready), 64'd0);
    snap = bus.bcd_out;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!bus.out_valid || bus.bin_ready || bus.bcd_out !== snap) stable = 1'b0;
    end
    if (hold > 0) check("hold_stable", 64'(stable), 64'd1);
    e = sb.pop_front();
    check("bcd_out", 64'(bus.bcd_out), 64'(e.bcd));
    check("blank_mask", 64'(bus.blank_mask), 64'(e.mask));
    check("ovf", 64'(bus.ovf), 64'(e.ovf));
    check("req_pulses", 64'(req_cnt - req0), 64'd1);
    check("next_pulses", 64'(next_cnt - next0), 64'd7);
    check("pulse_overlap_gap", 64'((overlap - ov0) + (gap_err - gap0)), 64'd0);
    bus.out_ready = 1'b1;
    bus.bin_valid = 1'b0;
    @(negedge clk);
    check("idle_after_done", 64'({bus.out_valid, bus.bin_ready}), 64'b01);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bit   seen;
    exp_t e;
    logic [26:0] rv;
    n_checks = 0;
    n_pass = 0;
    cyc = 0;
    req_cnt = 0; next_cnt = 0; overlap = 0; gap_err = 0; last_pulse = 0;
    mdl_val = 0; mdl_pos = 0; mdl_dly = 0;
    reset_n = 1'b1;
    bus.bin_valid = 1'b0;
    bus.bin_data  = '0;
    bus.out_ready = 1'b0;

    //          value        bcd            mask   ovf  hold early noise
    vecs[0] = '{27'd12345678,  32'h12345678, 8'h00, 1'b0, 0,  1'b1, 1'b0};
    vecs[1] = '{27'd0,         32'h00000000, 8'hFE, 1'b0, 0,  1'b0, 1'b0};
    vecs[2] = '{27'd405,       32'h00000405, 8'hF8, 1'b0, 0,  1'b0, 1'b0};
    vecs[3] = '{27'd99999999,  32'h99999999, 8'h00, 1'b0, 0,  1'b0, 1'b0};
    vecs[4] = '{27'd100000000, 32'hA0000000, 8'h00, 1'b1, 0,  1'b0, 1'b0};
    vecs[5] = '{27'd67108863,  32'h67108863, 8'h00, 1'b0, 10, 1'b0, 1'b1};
    vecs[6] = '{27'd7,         32'h00000007, 8'hFE, 1'b0, 3,  1'b0, 1'b0};

    #3 reset_n = 1'b0;
    #1 check_reset("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < 7; k++) begin
      e.bcd  = vecs[k].bcd;
      e.mask = vecs[k].mask;
      e.ovf  = vecs[k].ovf;
      sb.push_back(e);
      bus.out_ready = vecs[k].early;
      send(vecs[k].v, vecs[k].noise);
      get_result(vecs[k].hold);
    end

    for (int k = 0; k < 3; k++) begin
      rv = 27'($urandom_range(134217727, 0));
      sb.push_back(model(rv));
      send(rv, 1'b0);
      get_result(0);
    end

    // Reset in the 4th digit's WAIT window, then a fresh conversion
    send(27'd31415926, 1'b0);
    repeat (24) @(negedge clk);
    reset_n = 1'b0;
    #1 check_reset("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("no_partial_result", 64'(seen), 64'd0);
    e.bcd  = 32'h00000042;
    e.mask = 8'hFC;
    e.ovf  = 1'b0;
    sb.push_back(e);
    send(27'd42, 1'b0);
    get_result(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
